// File: rtl/cu_dispatch_scheduler.sv
// Dispatch scheduler: turns CU filter/ifmap/ack instructions into routed PE packets.
// Filters are unicast per PE row; ifmaps are broadcast, then gated on per-PE acks.
module cu_dispatch_scheduler #(
    parameter int unsigned MAX_PE = 3,
    parameter int unsigned MESH_X = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [44:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [52:0] out_data,
    output logic        busy,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, EMIT_FILT, EMIT_IFM, WAIT_ACK} state_t;

    localparam logic [2:0] MaxPe = 3'(MAX_PE);
    localparam logic [2:0] XLast = 3'(MESH_X - 1);

    state_t      state_q, state_d;
    logic [39:0] payload_q, payload_d;
    logic        ts_q, ts_d;
    logic        type_q, type_d;
    logic        loaded_q, loaded_d;
    logic        err_q, err_d;
    logic        busy_q;
    logic [2:0]  n_pe_q, n_pe_d;
    logic [2:0]  r_q, r_d;
    logic [2:0]  x_q, x_d;
    logic [2:0]  y_q, y_d;
    logic [7:0]  pend_q, pend_d;

    logic        accept;
    logic [2:0]  fsize;
    logic [3:0]  node;
    logic [7:0]  pend_sh;
    logic        node_hit;
    logic        last_row;

    assign accept   = in_valid & in_ready;
    assign fsize    = {1'b0, in_data[4:3]};
    assign node     = in_data[4:1];
    assign pend_sh  = pend_q >> node[2:0];
    assign node_hit = (node < {1'b0, n_pe_q}) & pend_sh[0];
    assign last_row = (r_q == n_pe_q - 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            payload_q <= '0;
            ts_q      <= 1'b0;
            type_q    <= 1'b0;
            loaded_q  <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            n_pe_q    <= '0;
            r_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            ts_q      <= ts_d;
            type_q    <= type_d;
            loaded_q  <= loaded_d;
            err_q     <= err_d;
            busy_q    <= (state_d != IDLE);
            n_pe_q    <= n_pe_d;
            r_q       <= r_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pend_q    <= pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        payload_d = payload_q;
        ts_d      = ts_q;
        type_d    = type_q;
        loaded_d  = loaded_q;
        err_d     = 1'b0;
        n_pe_d    = n_pe_q;
        r_d       = r_q;
        x_d       = x_q;
        y_d       = y_q;
        pend_d    = pend_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!in_data[0]) begin
                        err_d = 1'b1;
                    end else if (in_data[1] && (fsize == '0 || fsize > MaxPe)) begin
                        err_d = 1'b1;
                    end else if (!in_data[1] && !loaded_q) begin
                        err_d = 1'b1;
                    end else begin
                        payload_d = in_data[44:5];
                        ts_d      = in_data[2];
                        type_d    = in_data[1];
                        r_d       = '0;
                        x_d       = '0;
                        y_d       = '0;
                        if (in_data[1]) begin
                            n_pe_d   = fsize;
                            loaded_d = 1'b1;
                            state_d  = EMIT_FILT;
                        end else begin
                            state_d  = EMIT_IFM;
                        end
                    end
                end
            end
            EMIT_FILT, EMIT_IFM: begin
                if (out_ready) begin
                    if (last_row) begin
                        if (state_q == EMIT_FILT) begin
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_ACK;
                            pend_d  = (8'd1 << n_pe_q) - 8'd1;
                        end
                    end else begin
                        // Mesh coordinates walk row-major, so no divider is needed.
                        r_d = r_q + 3'd1;
                        if (x_q == XLast) begin
                            x_d = '0;
                            y_d = y_q + 3'd1;
                        end else begin
                            x_d = x_q + 3'd1;
                        end
                    end
                end
            end
            WAIT_ACK: begin
                if (accept) begin
                    if (node_hit) begin
                        pend_d = pend_q & ~(8'd1 << node[2:0]);
                        if (pend_d == '0) state_d = IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n & ((state_q == IDLE) | ((state_q == WAIT_ACK) & ~in_data[0]));
        out_valid = (state_q == EMIT_FILT) | (state_q == EMIT_IFM);
        out_data  = '0;
        if (out_valid) begin
            out_data = {payload_q, r_q, type_q, ts_q, y_q, x_q, (x_q != '0) ? 2'b01 : 2'b10};
        end
    end

    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_cu_dispatch_scheduler.sv
// Self-checking bench for cu_dispatch_scheduler: directed scenarios followed by
// random instruction traffic, compared against a transaction-level reference model.
module tb_cu_dispatch_scheduler;
    localparam int MAX_PE = 3;
    localparam int MESH_X = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [44:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [52:0] out_data;
    logic        busy;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: what has been loaded and which PEs still owe an ack
    bit       m_loaded = 1'b0;
    int       m_npe    = 0;
    bit [7:0] m_pend   = '0;

    cu_dispatch_scheduler #(.MAX_PE(MAX_PE), .MESH_X(MESH_X)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [44:0] filt(input logic [39:0] pl, input int s, input bit ts);
        logic [1:0] sz = 2'(s);
        return {pl, sz, ts, 2'b11};
    endfunction

    function automatic logic [44:0] ifm(input logic [39:0] pl, input bit ts);
        return {pl, 2'b00, ts, 2'b01};
    endfunction

    function automatic logic [44:0] ack(input int k);
        logic [3:0] kk = 4'(k);
        return {40'h0, kk, 1'b0};
    endfunction

    function automatic logic [52:0] pkt(input logic [39:0] pl, input int r, input bit typ, input bit ts);
        int x = r % MESH_X;
        int y = r / MESH_X;
        logic [2:0] rr = 3'(r);
        logic [2:0] xx = 3'(x);
        logic [2:0] yy = 3'(y);
        logic [1:0] dir = (x != 0) ? 2'b01 : 2'b10;
        return {pl, rr, typ, ts, yy, xx, dir};
    endfunction

    // mode 0: out_ready always 1, 1: toggling 1010..., 2: random
    task automatic drain(input int n, input logic [39:0] pl, input bit typ, input bit ts, input int mode);
        int r = 0;
        int g = 0;
        bit ordy;
        while (r < n && g < 200) begin
            check("out_valid", {63'd0, out_valid}, 64'd1);
            check("out_data", {11'd0, out_data}, {11'd0, pkt(pl, r, typ, ts)});
            check("busy_emit", {63'd0, busy}, 64'd1);
            ordy = (mode == 0) ? 1'b1 : (mode == 1) ? (g % 2 == 0) : 1'($urandom_range(0, 1));
            out_ready = ordy;
            @(negedge clk);
            g++;
            if (ordy) r++;
        end
        out_ready = 1'b0;
        check("drain_count", 64'(r), 64'(n));
    endtask

    task automatic issue(input logic [44:0] d, input int mode);
        bit waiting = (m_pend != '0);
        bit is_ack  = ~d[0];
        bit exp_err = 1'b0;
        bit emit    = 1'b0;
        bit pend_after = 1'b0;
        int n = 0;
        int k;
        int s;
        if (waiting && !is_ack) begin
            in_valid = 1'b1; in_data = d; #1;
            check("in_ready_held", {63'd0, in_ready}, 64'd0);
            @(negedge clk); #1;
            check("in_ready_held", {63'd0, in_ready}, 64'd0);
            check("no_out_wait", {63'd0, out_valid}, 64'd0);
            in_valid = 1'b0;
            @(negedge clk);
            return;
        end
        if (is_ack) begin
            k = int'(d[4:1]);
            if (!waiting || k >= m_npe) exp_err = 1'b1;
            else if (!m_pend[k]) exp_err = 1'b1;
            else m_pend[k] = 1'b0;
        end else if (d[1]) begin
            s = int'(d[4:3]);
            if (s == 0 || s > MAX_PE) exp_err = 1'b1;
            else begin m_npe = s; m_loaded = 1'b1; emit = 1'b1; n = s; end
        end else begin
            if (!m_loaded) exp_err = 1'b1;
            else begin emit = 1'b1; n = m_npe; pend_after = 1'b1; end
        end
        in_valid = 1'b1; in_data = d; #1;
        check("in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("err", {63'd0, err}, {63'd0, exp_err});
        if (emit) drain(n, d[44:5], d[1], d[2], mode);
        else check("no_out", {63'd0, out_valid}, 64'd0);
        if (pend_after) for (int i = 0; i < m_npe; i++) m_pend[i] = 1'b1;
        check("busy", {63'd0, busy}, {63'd0, (m_pend != '0)});
        if (exp_err) begin
            @(negedge clk);
            check("err_pulse", {63'd0, err}, 64'd0);
        end
    endtask

    initial begin
        logic [39:0] pl;
        int kind;
        rst_n = 1'b0; in_valid = 1'b1; in_data = filt(40'h5, 1, 1'b0); out_ready = 1'b0;

        // reset state
        @(negedge clk); @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {11'd0, out_data}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("rel_in_ready", {63'd0, in_ready}, 64'd1);

        // protocol errors with nothing loaded
        issue(ifm(40'hDEAD, 1'b0), 0);
        issue(filt(40'hBEEF, 0, 1'b0), 0);
        issue(ack(0), 0);

        // filter burst then ifmap broadcast under stalls, then acks
        issue(filt(40'h00_00_0A_0B_0C, 3, 1'b0), 0);
        issue(ifm(40'h12_34_56_78_9A, 1'b1), 1);
        issue(ack(2), 0);
        issue(ack(0), 0);
        issue(ack(0), 0);
        issue(ifm(40'h77, 1'b0), 0);
        issue(ack(3), 0);
        issue(ack(1), 0);
        issue(ifm(40'h88, 1'b0), 0);
        issue(ack(1), 0);
        issue(ack(0), 0);
        issue(ack(2), 0);

        // reset in the middle of a filter burst
        in_valid = 1'b1; in_data = filt(40'h1234, 2, 1'b1); #1;
        check("mid_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        check("mid_row0", {11'd0, out_data}, {11'd0, pkt(40'h1234, 0, 1'b1, 1'b1)});
        @(posedge clk); #1;
        check("mid_row1", {11'd0, out_data}, {11'd0, pkt(40'h1234, 1, 1'b1, 1'b1)});
        rst_n = 1'b0; #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_data", {11'd0, out_data}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b0;
        m_loaded = 1'b0; m_npe = 0; m_pend = '0;
        @(negedge clk);
        issue(ifm(40'h99, 1'b1), 0);

        // random traffic
        for (int it = 0; it < 80; it++) begin
            pl = {8'($urandom), $urandom};
            kind = $urandom_range(0, 9);
            if (kind < 3) issue(filt(pl, $urandom_range(0, 3), 1'($urandom)), 2);
            else if (kind < 5) issue(ifm(pl, 1'($urandom)), 2);
            else issue(ack($urandom_range(0, 4)), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
